// File: rtl/cache_assoc_lru_pkg.sv
// Shared types for the fully-associative LRU cache: FSM states, per-line
// status flags and the age-width helper.
package cache_assoc_lru_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WB     = 3'd2,
        ST_FILL   = 3'd3,
        ST_RESP   = 3'd4
    } cache_state_e;

    typedef struct packed {
        logic valid;
        logic dirty;
    } line_meta_t;

    // ceil(log2(ways)), never below one bit
    function automatic int age_width(input int ways);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < ways) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/cache_assoc_lru_if.sv
// Circuit-side request bus and memory-side handshake of the cache.
interface cache_assoc_lru_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 5
);
    logic              Req;
    logic              Write;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] BlockIn;
    logic              Busy;
    logic              Done;
    logic              Hit;
    logic [DATA_W-1:0] BlockOut;
    logic              Mem_Req;
    logic              C_Write_M;
    logic [ADDR_W-1:0] Mem_Address;
    logic [DATA_W-1:0] C_Block_M;
    logic [DATA_W-1:0] M_Block_C;
    logic              Mem_Ack;

    modport slave (
        input  Req, Write, Address, BlockIn, M_Block_C, Mem_Ack,
        output Busy, Done, Hit, BlockOut, Mem_Req, C_Write_M, Mem_Address, C_Block_M
    );

    modport master (
        output Req, Write, Address, BlockIn, M_Block_C, Mem_Ack,
        input  Busy, Done, Hit, BlockOut, Mem_Req, C_Write_M, Mem_Address, C_Block_M
    );
endinterface

// File: rtl/cache_lru_ages.sv
// Exact-LRU age registers: ages form a permutation of 0..WAYS-1, 0 = most recent.
module cache_lru_ages #(
    parameter int WAYS  = 4,
    parameter int AGE_W = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WAYS-1:0]  valid_vec,
    input  logic             touch_en,
    input  logic [AGE_W-1:0] touch_way,
    output logic [AGE_W-1:0] victim_way
);

    logic [AGE_W-1:0] ages_r [WAYS];

    // Age update: touched way becomes youngest, younger ways age by one
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < WAYS; i++) begin
                ages_r[i] <= AGE_W'(i);
            end
        end else if (touch_en) begin
            for (int i = 0; i < WAYS; i++) begin
                if (AGE_W'(i) == touch_way) begin
                    ages_r[i] <= AGE_W'(0);
                end else if (ages_r[i] < ages_r[touch_way]) begin
                    ages_r[i] <= ages_r[i] + AGE_W'(1);
                end
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the oldest way
    always_comb begin
        victim_way = AGE_W'(0);
        for (int i = 0; i < WAYS; i++) begin
            victim_way = (ages_r[i] == AGE_W'(WAYS - 1)) ? AGE_W'(i) : victim_way;
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            victim_way = valid_vec[i] ? victim_way : AGE_W'(i);
        end
    end

endmodule

// File: rtl/cache_assoc_lru.sv
// Fully-associative write-back / write-allocate cache, one word per line,
// full address as tag, exact LRU replacement.
module cache_assoc_lru
    import cache_assoc_lru_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 5,
    parameter int WAYS   = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    cache_assoc_lru_if.slave    bus
);

    localparam int AGE_W = age_width(WAYS);

    cache_state_e      state_r, state_s;
    logic              req_write_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic [DATA_W-1:0] req_data_r;
    logic [AGE_W-1:0]  way_r;
    logic              hit_r;

    line_meta_t        meta_r [WAYS];
    logic [ADDR_W-1:0] tag_r  [WAYS];
    logic [DATA_W-1:0] data_r [WAYS];

    logic              busy_r, done_r, hit_out_r, mem_req_r, c_write_m_r;
    logic [DATA_W-1:0] block_out_r, c_block_m_r;
    logic [ADDR_W-1:0] mem_addr_r;

    logic              lookup_hit_s, accept_s, touch_s, victim_dirty_s;
    logic [AGE_W-1:0]  lookup_way_s, victim_s;
    logic [WAYS-1:0]   valid_vec_s;

    assign bus.Busy        = busy_r;
    assign bus.Done        = done_r;
    assign bus.Hit         = hit_out_r;
    assign bus.BlockOut    = block_out_r;
    assign bus.Mem_Req     = mem_req_r;
    assign bus.C_Write_M   = c_write_m_r;
    assign bus.Mem_Address = mem_addr_r;
    assign bus.C_Block_M   = c_block_m_r;

    assign accept_s       = (state_r == ST_IDLE) && bus.Req && !busy_r;
    assign touch_s        = (state_r == ST_RESP);
    assign victim_dirty_s = meta_r[victim_s].valid && meta_r[victim_s].dirty;

    cache_lru_ages #(.WAYS(WAYS), .AGE_W(AGE_W)) u_ages (
        .Clock      (Clock),
        .Reset      (Reset),
        .valid_vec  (valid_vec_s),
        .touch_en   (touch_s),
        .touch_way  (way_r),
        .victim_way (victim_s)
    );

    // Parallel tag compare; scanning downwards lets the lowest index win
    always_comb begin
        logic match_s;
        lookup_hit_s = 1'b0;
        lookup_way_s = AGE_W'(0);
        valid_vec_s  = {WAYS{1'b0}};
        for (int i = WAYS - 1; i >= 0; i--) begin
            valid_vec_s[i] = meta_r[i].valid;
            match_s        = meta_r[i].valid && (tag_r[i] == req_addr_r);
            lookup_hit_s   = match_s ? 1'b1 : lookup_hit_s;
            lookup_way_s   = match_s ? AGE_W'(i) : lookup_way_s;
        end
    end

    // FSM state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = accept_s ? ST_LOOKUP : ST_IDLE;
            ST_LOOKUP: begin
                if (lookup_hit_s) begin
                    state_s = ST_RESP;
                end else if (victim_dirty_s) begin
                    state_s = ST_WB;
                end else begin
                    state_s = req_write_r ? ST_RESP : ST_FILL;
                end
            end
            ST_WB: begin
                if (bus.Mem_Ack) begin
                    state_s = req_write_r ? ST_RESP : ST_FILL;
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_FILL:   state_s = bus.Mem_Ack ? ST_RESP : ST_FILL;
            ST_RESP:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Request latch, line array and registered outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            hit_out_r   <= 1'b0;
            block_out_r <= {DATA_W{1'b0}};
            mem_req_r   <= 1'b0;
            c_write_m_r <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            c_block_m_r <= {DATA_W{1'b0}};
            req_write_r <= 1'b0;
            req_addr_r  <= {ADDR_W{1'b0}};
            req_data_r  <= {DATA_W{1'b0}};
            way_r       <= AGE_W'(0);
            hit_r       <= 1'b0;
            for (int i = 0; i < WAYS; i++) begin
                meta_r[i] <= '{valid: 1'b0, dirty: 1'b0};
                tag_r[i]  <= {ADDR_W{1'b0}};
                data_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    busy_r <= accept_s;
                    if (accept_s) begin
                        req_write_r <= bus.Write;
                        req_addr_r  <= bus.Address;
                        req_data_r  <= bus.BlockIn;
                    end
                end
                ST_LOOKUP: begin
                    hit_r <= lookup_hit_s;
                    way_r <= lookup_hit_s ? lookup_way_s : victim_s;
                    if (!lookup_hit_s && victim_dirty_s) begin
                        mem_req_r   <= 1'b1;
                        c_write_m_r <= 1'b1;
                        mem_addr_r  <= tag_r[victim_s];
                        c_block_m_r <= data_r[victim_s];
                    end else if (!lookup_hit_s && !req_write_r) begin
                        mem_req_r   <= 1'b1;
                        c_write_m_r <= 1'b0;
                        mem_addr_r  <= req_addr_r;
                    end
                end
                ST_WB: begin
                    if (bus.Mem_Ack) begin
                        // a read keeps Mem_Req high and turns straight into the fill
                        meta_r[way_r].dirty <= 1'b0;
                        mem_req_r           <= !req_write_r;
                        c_write_m_r         <= 1'b0;
                        mem_addr_r          <= req_write_r ? mem_addr_r : req_addr_r;
                    end
                end
                ST_FILL: begin
                    if (bus.Mem_Ack) begin
                        tag_r[way_r]  <= req_addr_r;
                        data_r[way_r] <= bus.M_Block_C;
                        meta_r[way_r] <= '{valid: 1'b1, dirty: 1'b0};
                        mem_req_r     <= 1'b0;
                    end
                end
                ST_RESP: begin
                    done_r    <= 1'b1;
                    hit_out_r <= hit_r;
                    if (req_write_r) begin
                        tag_r[way_r]  <= req_addr_r;
                        data_r[way_r] <= req_data_r;
                        meta_r[way_r] <= '{valid: 1'b1, dirty: 1'b1};
                    end else begin
                        block_out_r <= data_r[way_r];
                    end
                end
                default: busy_r <= 1'b0;
            endcase
        end
    end

endmodule
